// File: rtl/graph_adj_mem.sv
// Adjacency store: per-node base/degree table plus flat edge RAM, loaded by a streaming
// loader and then served one successor per request through a single per-query cursor.
module graph_adj_mem #(
  parameter int unsigned PARAM_NODE_IDX_WIDTH  = 10,
  parameter int unsigned PARAM_COUNTER_WIDTH   = 5,
  parameter int unsigned PARAM_EDGE_ADDR_WIDTH = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ld_valid,
  input  logic                            ld_first,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] ld_data,
  input  logic                            ld_done,
  output logic                            loaded,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] node_idx_reg,
  input  logic                            rd_next_node_reg,
  output logic                            rd_ready,
  output logic                            next_node_valid,
  output logic [PARAM_NODE_IDX_WIDTH-1:0] next_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]  next_node_counter,
  output logic                            err
);

  localparam int unsigned NW       = PARAM_NODE_IDX_WIDTH;
  localparam int unsigned CW       = PARAM_COUNTER_WIDTH;
  localparam int unsigned EW       = PARAM_EDGE_ADDR_WIDTH;
  localparam int unsigned NumNodes = 1 << NW;
  localparam int unsigned NumEdges = 1 << EW;
  localparam logic [CW-1:0] MaxDeg = '1;

  typedef enum logic {StLoad, StServe} ld_state_e;
  typedef enum logic [1:0] {StIdle, StTbl, StEdge, StResp} q_state_e;

  ld_state_e         r_ld_state;
  logic              r_loaded;
  logic [EW:0]       r_ptr;        // extra bit marks the edge RAM as full
  logic              r_open;
  logic [NW-1:0]     r_open_node;
  logic [CW-1:0]     r_open_deg;
  logic              r_err;
  logic [NumNodes-1:0] r_written;

  logic [EW-1:0]     r_base [NumNodes];
  logic [CW-1:0]     r_deg  [NumNodes];
  logic [NW-1:0]     r_edge [NumEdges];

  q_state_e          r_q_state;
  logic [NW-1:0]     r_q_node;
  logic [EW-1:0]     r_q_base;
  logic [CW-1:0]     r_q_deg;
  logic              r_cur_valid;
  logic [NW-1:0]     r_cur_node;
  logic [CW-1:0]     r_pos;
  logic              r_valid;
  logic [NW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;

  logic              w_ld_act;
  logic              w_open_wr;
  logic              w_edge_wr;
  logic              w_rd_ready;
  logic [EW-1:0]     w_edge_addr;

  assign w_ld_act    = (r_ld_state == StLoad) && ld_valid;
  assign w_open_wr   = w_ld_act && ld_first;
  assign w_edge_wr   = w_ld_act && !ld_first && r_open && (r_open_deg != MaxDeg) && !r_ptr[EW];
  assign w_rd_ready  = (r_q_state == StIdle) && r_loaded;
  assign w_edge_addr = r_q_base + EW'(r_pos);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_state  <= StLoad;
      r_loaded    <= 1'b0;
      r_ptr       <= '0;
      r_open      <= 1'b0;
      r_open_node <= '0;
      r_open_deg  <= '0;
      r_err       <= 1'b0;
      r_written   <= '0;
    end else if (r_ld_state == StLoad) begin
      if (w_open_wr) begin
        r_open             <= 1'b1;
        r_open_node        <= ld_data;
        r_open_deg         <= '0;
        r_written[ld_data] <= 1'b1;
      end else if (w_edge_wr) begin
        r_ptr      <= r_ptr + 1'b1;
        r_open_deg <= r_open_deg + 1'b1;
      end else if (w_ld_act) begin
        r_err <= 1'b1;
      end
      if (ld_done) begin
        r_open     <= 1'b0;
        r_loaded   <= 1'b1;
        r_ld_state <= StServe;
      end
    end
  end

  // Table/edge storage carries no reset; the written bitmap masks stale entries.
  always_ff @(posedge clk) begin
    if (w_open_wr) begin
      r_base[ld_data] <= r_ptr[EW-1:0];
      r_deg[ld_data]  <= '0;
    end
    if (w_edge_wr) begin
      r_edge[r_ptr[EW-1:0]] <= ld_data;
      r_deg[r_open_node]    <= r_open_deg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_state   <= StIdle;
      r_q_node    <= '0;
      r_q_base    <= '0;
      r_q_deg     <= '0;
      r_cur_valid <= 1'b0;
      r_cur_node  <= '0;
      r_pos       <= '0;
      r_valid     <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_q_state)
        StIdle: begin
          if (rd_next_node_reg && w_rd_ready) begin
            r_q_node  <= node_idx_reg;
            r_q_state <= StTbl;
          end
        end
        StTbl: begin
          r_q_base <= r_base[r_q_node];
          r_q_deg  <= r_written[r_q_node] ? r_deg[r_q_node] : '0;
          if (!r_cur_valid || (r_cur_node != r_q_node)) begin
            r_cur_valid <= 1'b1;
            r_cur_node  <= r_q_node;
            r_pos       <= '0;
          end
          r_q_state <= StEdge;
        end
        StEdge: begin
          r_valid <= 1'b1;
          if (r_pos < r_q_deg) begin
            r_idx <= r_edge[w_edge_addr];
            r_cnt <= r_q_deg - r_pos;
            r_pos <= r_pos + 1'b1;
          end else begin
            r_idx <= '0;
            r_cnt <= '0;
          end
          r_q_state <= StResp;
        end
        StResp: begin
          r_valid   <= 1'b0;
          r_q_state <= StIdle;
        end
        default: r_q_state <= StIdle;
      endcase
    end
  end

  assign loaded            = r_loaded;
  assign rd_ready          = w_rd_ready;
  assign next_node_valid   = r_valid;
  assign next_node_idx     = r_idx;
  assign next_node_counter = r_cnt;
  assign err               = r_err;

endmodule

// File: tb/tb_graph_adj_mem.sv
// Bench for graph_adj_mem: directed scenarios plus randomized load/query rounds
// checked against a list-of-queues reference model.
module tb_graph_adj_mem;

  localparam int NW = 10;
  localparam int CW = 5;
  localparam int EW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid, ld_first, ld_done;
  logic [NW-1:0] ld_data;
  logic          loaded;
  logic [NW-1:0] node_idx_reg;
  logic          rd_next_node_reg;
  logic          rd_ready;
  logic          next_node_valid;
  logic [NW-1:0] next_node_idx;
  logic [CW-1:0] next_node_counter;
  logic          err;

  graph_adj_mem #(
    .PARAM_NODE_IDX_WIDTH (NW),
    .PARAM_COUNTER_WIDTH  (CW),
    .PARAM_EDGE_ADDR_WIDTH(EW)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .ld_valid         (ld_valid),
    .ld_first         (ld_first),
    .ld_data          (ld_data),
    .ld_done          (ld_done),
    .loaded           (loaded),
    .node_idx_reg     (node_idx_reg),
    .rd_next_node_reg (rd_next_node_reg),
    .rd_ready         (rd_ready),
    .next_node_valid  (next_node_valid),
    .next_node_idx    (next_node_idx),
    .next_node_counter(next_node_counter),
    .err              (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each node's successor list as a queue.
  int unsigned m_list [1024][$];
  int          m_open;
  int          m_ptr;
  bit          m_err;
  bit          m_loaded;
  bit          m_cur_valid;
  int          m_cur_node;
  int          m_pos;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_list[i].delete();
    m_open      = -1;
    m_ptr       = 0;
    m_err       = 1'b0;
    m_loaded    = 1'b0;
    m_cur_valid = 1'b0;
    m_cur_node  = 0;
    m_pos       = 0;
  endtask

  task automatic model_beat(input bit first, input int data);
    if (m_loaded) return;
    if (first) begin
      m_list[data].delete();
      m_open = data;
    end else if (m_open < 0 || m_list[m_open].size() >= 31 || m_ptr >= 2048) begin
      m_err = 1'b1;
    end else begin
      m_list[m_open].push_back(data);
      m_ptr++;
    end
  endtask

  task automatic model_query(input int node, output int exp_idx, output int exp_cnt);
    if (!m_cur_valid || m_cur_node != node) begin
      m_cur_valid = 1'b1;
      m_cur_node  = node;
      m_pos       = 0;
    end
    if (m_pos < m_list[node].size()) begin
      exp_idx = int'(m_list[node][m_pos]);
      exp_cnt = m_list[node].size() - m_pos;
      m_pos++;
    end else begin
      exp_idx = 0;
      exp_cnt = 0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ld_valid = 0; ld_first = 0; ld_data = '0; ld_done = 0;
    rd_next_node_reg = 0; node_idx_reg = '0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic ld_beat(input bit first, input int data, input bit done);
    ld_valid = 1'b1;
    ld_first = first;
    ld_data  = NW'(data);
    ld_done  = done;
    tick();
    ld_valid = 1'b0;
    ld_done  = 1'b0;
    model_beat(first, data);
    if (done) begin
      m_open   = -1;
      m_loaded = 1'b1;
    end
  endtask

  task automatic ld_finish();
    ld_done = 1'b1;
    tick();
    ld_done  = 1'b0;
    m_open   = -1;
    m_loaded = 1'b1;
    check_eq("loaded_after_done", 32'(loaded), 1);
    check_eq("err_after_load", 32'(err), 32'(m_err));
  endtask

  task automatic load_list(input int node, input int n, input int base_val);
    ld_beat(1'b1, node, 1'b0);
    for (int i = 0; i < n; i++) ld_beat(1'b0, (base_val + i) % 1024, 1'b0);
  endtask

  task automatic query(input int node);
    int exp_idx, exp_cnt, waited;
    waited = 0;
    while (!rd_ready && waited < 10) begin
      tick();
      waited++;
    end
    if (!rd_ready) begin
      check_eq("rd_ready_timeout", 32'(rd_ready), 1);
      return;
    end
    model_query(node, exp_idx, exp_cnt);
    node_idx_reg     = NW'(node);
    rd_next_node_reg = 1'b1;
    tick();
    rd_next_node_reg = 1'b0;
    check_eq("valid_n1", 32'(next_node_valid), 0);
    tick();
    check_eq("valid_n2", 32'(next_node_valid), 0);
    tick();
    check_eq("valid_n3", 32'(next_node_valid), 1);
    check_eq("resp_idx", 32'(next_node_idx), 32'(exp_idx));
    check_eq("resp_cnt", 32'(next_node_counter), 32'(exp_cnt));
    tick();
    check_eq("valid_drop", 32'(next_node_valid), 0);
    check_eq("idx_hold", 32'(next_node_idx), 32'(exp_idx));
  endtask

  initial begin
    int n_lists, deg, node, qn;
    apply_reset();
    check_eq("rst_loaded", 32'(loaded), 0);
    check_eq("rst_rd_ready", 32'(rd_ready), 0);
    check_eq("rst_valid", 32'(next_node_valid), 0);
    check_eq("rst_idx", 32'(next_node_idx), 0);
    check_eq("rst_cnt", 32'(next_node_counter), 0);
    check_eq("rst_err", 32'(err), 0);

    // Basic list, exhaustion, cursor restart, ignored load beats in SERVE.
    ld_beat(1'b1, 3, 1'b0);
    ld_beat(1'b0, 5, 1'b0);
    ld_beat(1'b0, 7, 1'b0);
    check_eq("rd_ready_in_load", 32'(rd_ready), 0);
    ld_beat(1'b0, 9, 1'b1);
    check_eq("loaded_done_with_beat", 32'(loaded), 1);
    for (int i = 0; i < 4; i++) query(3);
    query(3);
    query(8);
    query(3);
    ld_beat(1'b1, 8, 1'b0);
    ld_beat(1'b0, 1, 1'b0);
    query(8);
    query(3);

    // Orphan successor, degree overflow, reopened list.
    apply_reset();
    ld_beat(1'b0, 12, 1'b0);
    check_eq("err_orphan", 32'(err), 1);
    check_eq("rd_ready_before_done", 32'(rd_ready), 0);
    load_list(1, 32, 100);
    load_list(2, 1, 4);
    load_list(2, 1, 6);
    ld_finish();
    query(1);
    query(1);
    query(2);
    query(2);
    query(12);

    // Reset while the query is in EDGE.
    apply_reset();
    load_list(3, 1, 5);
    load_list(4, 1, 1);
    ld_finish();
    node_idx_reg     = NW'(3);
    rd_next_node_reg = 1'b1;
    tick();
    rd_next_node_reg = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_eq("abort_valid", 32'(next_node_valid), 0);
    check_eq("abort_loaded", 32'(loaded), 0);
    check_eq("abort_rd_ready", 32'(rd_ready), 0);
    tick();
    rst = 1'b0;
    model_reset();
    load_list(4, 1, 2);
    ld_finish();
    query(3);
    query(4);

    // Fill the edge RAM past its capacity.
    apply_reset();
    for (int n = 0; n < 70; n++) load_list(100 + n, 31, n * 7);
    ld_finish();
    query(166);
    query(167);
    query(100);

    // Randomized rounds.
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      n_lists = $urandom_range(1, 40);
      for (int l = 0; l < n_lists; l++) begin
        if ($urandom_range(0, 15) == 0) ld_beat(1'b0, $urandom_range(0, 1023), 1'b0);
        node = $urandom_range(0, 31);
        deg  = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 34) : $urandom_range(0, 8);
        load_list(node, deg, $urandom_range(0, 1023));
      end
      ld_finish();
      for (int q = 0; q < 30; q++) begin
        qn = $urandom_range(0, 7);
        for (int k = 0; k < $urandom_range(1, 4); k++) query(qn);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/graph_adj_mem.md
Name: graph_adj_mem

Overview:
- Adjacency store directly upstream of digital_top in the graph path-counting design.
- A loader (parser/UART side) streams each node's successor list into it.
- Once loaded, it serves digital_top's read requests (node_idx_reg / rd_next_node_reg) one successor per request, returning next_node_idx and next_node_counter.
- Per-node base/degree table plus a flat edge RAM, with a single per-query cursor.

Parameters:
- PARAM_NODE_IDX_WIDTH, 10: node index width; node table has 2^10 entries.
- PARAM_COUNTER_WIDTH, 5: degree/remaining-count width; max degree 31.
- PARAM_EDGE_ADDR_WIDTH, 11: edge RAM address width; 2048 edges.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset.
- ld_valid  in  1  load beat valid.
- ld_first  in  1  beat opens a new list; ld_data is the source node.
- ld_data  in  PARAM_NODE_IDX_WIDTH  source node (ld_first=1) or successor node (ld_first=0).
- ld_done  in  1  pulse: loading finished.
- loaded  out  1  table ready for queries.
- node_idx_reg  in  PARAM_NODE_IDX_WIDTH  queried node.
- rd_next_node_reg  in  1  request next successor of node_idx_reg.
- rd_ready  out  1  request accepted this cycle if asserted.
- next_node_valid  out  1  one-cycle response strobe.
- next_node_idx  out  PARAM_NODE_IDX_WIDTH  returned successor.
- next_node_counter  out  PARAM_COUNTER_WIDTH  successors remaining, including the returned one.
- err  out  1  sticky error flag.

Interface decision (fixed):
- One clock; reset is asynchronous and active-high.
- Port names are clk and rst.

Behaviour:
- Reset values:
  - loaded=0, rd_ready=0, next_node_valid=0, next_node_idx=0, next_node_counter=0, err=0.
  - Edge write pointer=0; cursor invalid.
  - Per-node written-bitmap cleared: unwritten nodes read as degree 0.
  - Base/edge RAM contents need not reset.
- Load FSM, states LOAD and SERVE:
  - LOAD is entered from reset.
  - ld_valid & ld_first: close the current list. Open entry ld_data with base=write pointer, deg=0, and set its bitmap bit.
  - ld_valid & !ld_first: write ld_data to edge[ptr]; ptr++, deg++.
  - A successor beat before any ld_first: ignored, err=1.
  - deg would exceed 31, or ptr would wrap past 2^EDGE_ADDR_WIDTH-1: beat dropped, err=1.
  - Reopening an already-written node overwrites its entry (last list wins); edges are not reclaimed.
  - ld_done: closes the open list. Next cycle loaded=1 and state=SERVE. ld_done together with ld_valid processes the beat first.
  - In SERVE, ld_* are ignored. Only rst returns to LOAD.
- Query FSM, states IDLE, TBL, EDGE, RESP:
  - rd_ready=1 only in IDLE with loaded=1. A request is taken when rd_next_node_reg & rd_ready.
  - TBL: read base/deg of node_idx_reg. If node ≠ cursor node, or cursor invalid, set cursor node=node_idx_reg, pos=0.
  - EDGE: if pos<deg, read edge[base+pos].
  - RESP: next_node_valid=1 for exactly 1 cycle.
    - If pos<deg: next_node_idx=edge data, next_node_counter=deg-pos, then pos++.
    - Else: next_node_idx=0, next_node_counter=0.
  - Return to IDLE.
  - Latency: request at cycle N gives response at N+3. Maximum issue rate is one request per 4 cycles.
  - next_node_idx/next_node_counter hold their values until the next response.
- Cursor rules:
  - A request for a different node restarts that node from pos 0.
  - Re-requesting the same node after exhaustion keeps returning counter 0.
  - A node never loaded returns counter 0.
- Requests while rd_ready=0 are ignored, not queued.
- rst mid-load or mid-query:
  - Aborts immediately; all outputs go to reset values.
  - The bitmap clears, so all data is effectively erased.

Test Plan:
- Load AAA(3)->{5,7,9}, ld_done; query node 3 four times -> (5,3),(7,2),(9,1),(0,0), each response 3 cycles after its request; loaded=1.
- Query node 3 once -> (5,3); then query node 8 (never loaded) -> (0,0); then node 3 -> (5,3), showing cursor restart.
- Load node 1 with 32 successors -> first 31 stored, err=1; querying node 1 first returns counter 31.
- Successor beat before any ld_first -> err=1, nothing stored; rd_ready stays 0 until ld_done.
- Load node 2->{4}, then node 2 reopened->{6}; query node 2 -> (6,1) then (0,0).
- Assert rst during EDGE state -> next cycle next_node_valid=0, loaded=0; query of a previously loaded node after reload without it -> (0,0).
